multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Control FSM of the multicycle RV32 core; the producer side of the ALU control interface.
//  Decodes op/funct3/funct7b5, drives ALUControl, mux selects and write enables each cycle.
//  Consumes ALU Zero/Negative flags to resolve branches. Sits between instruction register and datapath.
// PARAMETERS
//  ALUCTRL_W  5  width of ALUControl (fixed encoding, see package)
//  OP_W       7  opcode width
// PORTS
//  clk         in   1  single clock, rising edge
//  rst_n       in   1  synchronous reset, active-low
//  op          in   7  instr[6:0] from instruction register
//  funct3      in   3  instr[14:12]
//  funct7b5    in   1  instr[30]
//  Zero        in   1  ALU result == 0
//  Negative    in   1  ALU result[31]
//  ALUControl  out  5  ADD 00010, SUB 01010, OR 00111, AND 00011, SLL 00000, SRL 10000, SLT 00001
//  ALUSrcA     out  2  00 PC, 01 OldPC, 10 rs1
//  ALUSrcB     out  2  00 rs2, 01 Imm, 10 const 4
//  ResultSrc   out  2  00 ALUOut, 01 ReadData, 10 ALUResult
//  ImmSrc      out  2  00 I, 01 S, 10 B, 11 J; decoded from op
//  AdrSrc      out  1  0 PC, 1 ALUOut
//  IRWrite, PCWrite, RegWrite, MemWrite  out 1 each  write enables
//  IllegalOp   out  1  one-cycle pulse in Decode on unsupported opcode
// BEHAVIOUR
//  - Moore FSM; outputs combinational from state (+ op/funct/flags as noted); state register only.
//  - Reset: rst_n low at edge -> state=FETCH. While rst_n low, IRWrite/PCWrite/RegWrite/MemWrite/IllegalOp forced 0.
//    Reset mid-instruction abandons it; no write occurs in the reset cycle.
//  - FETCH: AdrSrc0 IRWrite1 SrcA00 SrcB10 ADD ResultSrc10 PCUpdate -> DECODE
//  - DECODE: SrcA01 SrcB01 ADD (branch target into ALUOut). Next by op:
//    0000011/0100011->MEMADR; 0110011->EXECR; 0010011->EXECI; 1101111->JAL; 1100011->BRANCH;
//    other -> FETCH with IllegalOp=1 for this cycle.
//  - MEMADR: SrcA10 SrcB01 ADD -> MEMREAD (lw) / MEMWRITE (sw)
//  - MEMREAD: ResultSrc00 AdrSrc1 -> MEMWB;  MEMWB: ResultSrc01 RegWrite1 -> FETCH
//  - MEMWRITE: ResultSrc00 AdrSrc1 MemWrite1 -> FETCH
//  - EXECR: SrcA10 SrcB00 ALU-decode -> ALUWB;  EXECI: SrcA10 SrcB01 ALU-decode -> ALUWB
//  - ALUWB: ResultSrc00 RegWrite1 -> FETCH
//  - JAL: SrcA01 SrcB10 ADD ResultSrc00 PCUpdate -> ALUWB
//  - BRANCH: SrcA10 SrcB00 SUB ResultSrc00 Branch -> FETCH
//  - PCWrite = PCUpdate | (Branch & taken); taken evaluated on flags in BRANCH cycle.
//  - ALU decode (funct3): 000 ADD, or SUB iff op==0110011 & funct7b5; 001 SLL; 101 SRL;
//    010 SLT; 110 OR; 111 AND; 011/100 -> ADD. Non-EXEC states use fixed ADD/SUB as listed.
//  - Latency: lw 5, sw 4, R/I 4, jal 4, branch 3 cycles; illegal 2 cycles.
//  - Unused/undefined state encodings -> FETCH next cycle, all enables 0.
// CONFIGURATION
//  BRANCH_EXT_EN defined: taken = beq(000) Zero; bne(001) ~Zero; blt(100) Negative;
//    bge(101) ~Negative. Signed overflow ignored (Negative of SUB result). Others not taken.
//  Undefined: only beq(000) taken on Zero; any other funct3 never taken, no IllegalOp.
// STRUCTURE
//  Package riscv_ctrl_pkg: state enum (FETCH..BRANCH), ALUControl localparams, opcode
//    localparams, ALUSrcA/B, ResultSrc and ImmSrc encodings; shared with datapath and alu.
//  Sub-module alu_decoder: combinational op/funct3/funct7b5/ALUOp -> ALUControl.
// TESTING
//  1 rst_n=0 two cycles in MEMWRITE -> next state FETCH, MemWrite=0 during reset, IRWrite=1 after release.
//  2 op=0000011 -> states FETCH,DECODE,MEMADR,MEMREAD,MEMWB; RegWrite=1 only in 5th cycle, ResultSrc=01.
//  3 op=0110011 funct3=000 funct7b5=1 -> ALUControl=01010 in EXECR; funct3=110 -> 00111.
//  4 op=1100011 funct3=000 Zero=1 -> PCWrite=1 in BRANCH; Zero=0 -> PCWrite=0; back to FETCH.
//  5 BRANCH_EXT_EN: funct3=100 Negative=1 -> PCWrite=1; undefined: same stimulus -> PCWrite=0.
//  6 op=1111111 -> IllegalOp pulses 1 cycle in DECODE, next state FETCH, no write enables asserted.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32 control path: FSM states, ALU control
// codes, opcodes and datapath mux selects used by controller, datapath and ALU.
package riscv_ctrl_pkg;

    localparam int ALUCTRL_W = 5;
    localparam int OP_W      = 7;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        JAL      = 4'd8,
        ALUWB    = 4'd9,
        BRANCH   = 4'd10
    } state_t;

    // Fixed ALU operation selected by the FSM; ALUOP_FUNCT defers to funct3/funct7b5.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [ALUCTRL_W-1:0] ALU_ADD = 5'b00010;
    localparam logic [ALUCTRL_W-1:0] ALU_SUB = 5'b01010;
    localparam logic [ALUCTRL_W-1:0] ALU_OR  = 5'b00111;
    localparam logic [ALUCTRL_W-1:0] ALU_AND = 5'b00011;
    localparam logic [ALUCTRL_W-1:0] ALU_SLL = 5'b00000;
    localparam logic [ALUCTRL_W-1:0] ALU_SRL = 5'b10000;
    localparam logic [ALUCTRL_W-1:0] ALU_SLT = 5'b00001;

    localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
    localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_READDATA  = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decode: fixed ADD/SUB from the FSM, or funct3/funct7b5
// decode for EXEC states (SUB only for R-type with funct7b5 set).
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [OP_W-1:0]      op,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  alu_op_t              alu_op,
    output logic [ALUCTRL_W-1:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op == OP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control = ALU_SLL;
                    3'b101:  alu_control = ALU_SRL;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM of the multicycle RV32 core. Define BRANCH_EXT_EN to resolve
// bne/blt/bge in addition to beq.
module multicycle_controller
    import riscv_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [OP_W-1:0]      op,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 Zero,
    input  logic                 Negative,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ImmSrc,
    output logic                 AdrSrc,
    output logic                 IRWrite,
    output logic                 PCWrite,
    output logic                 RegWrite,
    output logic                 MemWrite,
    output logic                 IllegalOp
);

    state_t  state_q, state_d;
    alu_op_t alu_op;
    logic    ir_write, pc_update, branch, reg_write, mem_write, illegal;
    logic    taken;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        alu_op    = ALUOP_ADD;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        ResultSrc = RES_ALUOUT;
        AdrSrc    = 1'b0;
        ir_write  = 1'b0;
        pc_update = 1'b0;
        branch    = 1'b0;
        reg_write = 1'b0;
        mem_write = 1'b0;
        illegal   = 1'b0;
        case (state_q)
            FETCH: begin
                ir_write  = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                pc_update = 1'b1;
                state_d   = DECODE;
            end
            DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_RTYPE:          state_d = EXECR;
                    OP_ITYPE:          state_d = EXECI;
                    OP_JAL:            state_d = JAL;
                    OP_BRANCH:         state_d = BRANCH;
                    default: begin
                        state_d = FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                state_d = (op == OP_STORE) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                ResultSrc = RES_READDATA;
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            MEMWRITE: begin
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
                state_d   = FETCH;
            end
            EXECR: begin
                ALUSrcA = SRCA_RS1;
                alu_op  = ALUOP_FUNCT;
                state_d = ALUWB;
            end
            EXECI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALUOP_FUNCT;
                state_d = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                pc_update = 1'b1;
                state_d   = ALUWB;
            end
            BRANCH: begin
                ALUSrcA = SRCA_RS1;
                alu_op  = ALUOP_SUB;
                branch  = 1'b1;
                state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

`ifdef BRANCH_EXT_EN
    // Signed compare uses the raw sign of rs1-rs2; overflow is deliberately ignored.
    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = Zero;
            3'b001:  taken = ~Zero;
            3'b100:  taken = Negative;
            3'b101:  taken = ~Negative;
            default: taken = 1'b0;
        endcase
    end
`else
    logic unused_negative;
    assign unused_negative = Negative;
    assign taken = (funct3 == 3'b000) && Zero;
`endif

    always_comb begin
        ImmSrc = IMM_I;
        case (op)
            OP_STORE:  ImmSrc = IMM_S;
            OP_BRANCH: ImmSrc = IMM_B;
            OP_JAL:    ImmSrc = IMM_J;
            default:   ImmSrc = IMM_I;
        endcase
    end

    alu_decoder u_alu_decoder (
        .op          (op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .alu_op      (alu_op),
        .alu_control (ALUControl)
    );

    // All side effects are suppressed during the reset cycle, even mid-instruction.
    assign IRWrite   = rst_n & ir_write;
    assign PCWrite   = rst_n & (pc_update | (branch & taken));
    assign RegWrite  = rst_n & reg_write;
    assign MemWrite  = rst_n & mem_write;
    assign IllegalOp = rst_n & illegal;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expectations are queued by
// the stimulus and compared by an independent monitor on the falling edge.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = 7'b0;
    logic [2:0] funct3 = 3'b0;
    logic       funct7b5 = 1'b0;
    logic       Zero = 1'b0;
    logic       Negative = 1'b0;
    logic [4:0] ALUControl;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic       AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, IllegalOp;

`ifdef BRANCH_EXT_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [18:0] exp;
        logic [18:0] mask;
    } sb_t;

    sb_t sb_q[$];
    int  checks = 0;
    int  failures = 0;

    logic [6:0] cur_op;
    logic [2:0] cur_f3;
    logic       cur_f7, cur_z, cur_n;
    logic [1:0] cur_imm;
    logic       imm_care;

    multicycle_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .Negative   (Negative),
        .ALUControl (ALUControl),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .AdrSrc     (AdrSrc),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .IllegalOp  (IllegalOp)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] mkv(input logic [4:0] alu, input logic [1:0] a,
                                        input logic [1:0] b, input logic [1:0] res,
                                        input logic adr, input logic ir, input logic pc,
                                        input logic rg, input logic mem, input logic ill);
        return {alu, a, b, res, cur_imm, adr, ir, pc, rg, mem, ill};
    endfunction

    function automatic logic [18:0] mk(input logic [18:0] m);
        return imm_care ? m : (m & ~19'h000C0);
    endfunction

    task automatic applyStimulus(input string name, input logic rstn,
                                 input logic [18:0] exp, input logic [18:0] mask);
        sb_t r;
        @(posedge clk);
        #1;
        rst_n    = rstn;
        op       = cur_op;
        funct3   = cur_f3;
        funct7b5 = cur_f7;
        Zero     = cur_z;
        Negative = cur_n;
        r.name = name;
        r.exp  = exp;
        r.mask = mask;
        sb_q.push_back(r);
    endtask

    task automatic checkOutput(input sb_t r);
        logic [18:0] act;
        act = {ALUControl, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, AdrSrc,
               IRWrite, PCWrite, RegWrite, MemWrite, IllegalOp};
        checks++;
        if (((act ^ r.exp) & r.mask) != 19'h0) begin
            failures++;
            $display("[TB] FAIL %s actual=%05h required=%05h mask=%05h",
                     r.name, act, r.exp, r.mask);
        end
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic [1:0] imm, input logic care);
        cur_op = o; cur_f3 = f3; cur_f7 = f7; cur_imm = imm; imm_care = care;
    endtask

    task automatic c_reset(input string n);
        applyStimulus(n, 1'b0, 19'h0, 19'h0001F);
    endtask
    task automatic c_fetch(input string n);
        applyStimulus(n, 1'b1, mkv(5'b00010, 2'b00, 2'b10, 2'b10, 0, 1, 1, 0, 0, 0), mk(19'h7FFFF));
    endtask
    task automatic c_decode(input string n);
        applyStimulus(n, 1'b1, mkv(5'b00010, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0), mk(19'h7FCDF));
    endtask
    task automatic c_memadr(input string n);
        applyStimulus(n, 1'b1, mkv(5'b00010, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0), mk(19'h7FCDF));
    endtask
    task automatic c_exec(input string n, input logic [4:0] alu, input logic imm_b);
        applyStimulus(n, 1'b1, mkv(alu, 2'b10, imm_b ? 2'b01 : 2'b00, 2'b00, 0, 0, 0, 0, 0, 0),
                      mk(19'h7FCDF));
    endtask
    task automatic c_aluwb(input string n);
        applyStimulus(n, 1'b1, mkv(5'b00010, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0), mk(19'h003DF));
    endtask
    task automatic c_branch(input string n, input logic pc);
        applyStimulus(n, 1'b1, mkv(5'b01010, 2'b10, 2'b00, 2'b00, 0, 0, pc, 0, 0, 0), mk(19'h7FFDF));
    endtask

    task automatic run_alu(input string n, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic [4:0] alu);
        set_instr(o, f3, f7, 2'b00, o == 7'b0010011);
        c_fetch({n, "_fetch"});
        c_decode({n, "_decode"});
        c_exec({n, "_exec"}, alu, o == 7'b0010011);
        c_aluwb({n, "_aluwb"});
    endtask

    task automatic run_branch(input string n, input logic [2:0] f3, input logic z,
                              input logic neg, input logic pc);
        set_instr(7'b1100011, f3, 1'b0, 2'b10, 1'b1);
        cur_z = z; cur_n = neg;
        c_fetch({n, "_fetch"});
        c_decode({n, "_decode"});
        c_branch({n, "_branch"}, pc);
        cur_z = 1'b0; cur_n = 1'b0;
    endtask

    // Monitor: compare every queued expectation against the outputs at mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) checkOutput(sb_q.pop_front());
        end
    end

    initial begin
        cur_z = 1'b0; cur_n = 1'b0;
        set_instr(7'b0000011, 3'b010, 1'b0, 2'b00, 1'b1);
        c_reset("init_reset0");
        c_reset("init_reset1");

        c_fetch("lw_fetch");
        c_decode("lw_decode");
        c_memadr("lw_memadr");
        applyStimulus("lw_memread", 1'b1, mkv(5'b00010, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0), mk(19'h003FF));
        applyStimulus("lw_memwb", 1'b1, mkv(5'b00010, 2'b00, 2'b00, 2'b01, 0, 0, 0, 1, 0, 0), mk(19'h003DF));

        set_instr(7'b0100011, 3'b010, 1'b0, 2'b01, 1'b1);
        c_fetch("sw_fetch");
        c_decode("sw_decode");
        c_memadr("sw_memadr");
        c_reset("sw_memwrite_in_reset");
        c_reset("sw_fetch_in_reset");
        c_fetch("sw_fetch_after_reset");
        c_decode("sw2_decode");
        c_memadr("sw2_memadr");
        applyStimulus("sw2_memwrite", 1'b1, mkv(5'b00010, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 1, 0), mk(19'h003FF));

        run_alu("r_sub", 7'b0110011, 3'b000, 1'b1, 5'b01010);
        run_alu("r_or",  7'b0110011, 3'b110, 1'b0, 5'b00111);
        run_alu("r_and", 7'b0110011, 3'b111, 1'b0, 5'b00011);
        run_alu("r_slt", 7'b0110011, 3'b010, 1'b0, 5'b00001);
        run_alu("i_add_f7", 7'b0010011, 3'b000, 1'b1, 5'b00010);
        run_alu("i_srl", 7'b0010011, 3'b101, 1'b0, 5'b10000);
        run_alu("i_sll", 7'b0010011, 3'b001, 1'b0, 5'b00000);
        run_alu("i_f3_100", 7'b0010011, 3'b100, 1'b0, 5'b00010);

        set_instr(7'b1101111, 3'b000, 1'b0, 2'b11, 1'b1);
        c_fetch("jal_fetch");
        c_decode("jal_decode");
        applyStimulus("jal_jal", 1'b1, mkv(5'b00010, 2'b01, 2'b10, 2'b00, 0, 0, 1, 0, 0, 0), mk(19'h7FFDF));
        c_aluwb("jal_aluwb");

        run_branch("beq_taken", 3'b000, 1'b1, 1'b0, 1'b1);
        run_branch("beq_not", 3'b000, 1'b0, 1'b0, 1'b0);
        run_branch("blt_neg", 3'b100, 1'b0, 1'b1, EXT);
        run_branch("bne_nz", 3'b001, 1'b0, 1'b0, EXT);
        run_branch("bge_neg", 3'b101, 1'b0, 1'b1, 1'b0);

        set_instr(7'b1111111, 3'b000, 1'b0, 2'b00, 1'b0);
        c_fetch("ill_fetch");
        applyStimulus("ill_decode", 1'b1, mkv(5'b00010, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 1), mk(19'h7FCDF));
        set_instr(7'b0110011, 3'b000, 1'b0, 2'b00, 1'b0);
        c_fetch("ill_back_to_fetch");
        c_decode("post_ill_decode");

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        if (sb_q.size() > 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
